// File: rtl/sdram_cmd_seq_param_if.sv
// Controller-side bus of the SDRAM command sequencer.
// Request strobe and opcode in, command stream and status out.
interface sdram_cmd_seq_param_if;
  logic       start;
  logic [2:0] opcode;
  logic       mode;
  logic [3:0] command;
  logic       chip;
  logic       idle;
  logic       done;
  logic       init_done;
  logic       mode_cur;

  modport master (
    output start, opcode, mode,
    input  command, chip, idle, done,
    input  init_done, mode_cur
  );

  modport slave (
    input  start, opcode, mode,
    output command, chip, idle, done,
    output init_done, mode_cur
  );
endinterface

// File: rtl/sdram_cmd_seq_param.sv
// Parametrised SDRAM command sequencer.
// One down-counter times every wait; steps chain through a return slot.
module sdram_cmd_seq_param #(
  parameter int BURST_LEN = 4,
  parameter int CAS_LAT   = 2,
  parameter int TRCD      = 2,
  parameter int TRP       = 2,
  parameter int TRFC      = 9,
  parameter int TMRD      = 2,
  parameter int TWR       = 2,
  parameter int TXSR      = 10,
  parameter int INIT_WAIT = 14285,
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic rst,
  sdram_cmd_seq_param_if.slave bus
);

  localparam logic [3:0] C_NOP  = 4'd0;
  localparam logic [3:0] C_ACT  = 4'd1;
  localparam logic [3:0] C_RDA  = 4'd2;
  localparam logic [3:0] C_WRA  = 4'd3;
  localparam logic [3:0] C_PRE  = 4'd4;
  localparam logic [3:0] C_AREF = 4'd5;
  localparam logic [3:0] C_SREF = 4'd6;
  localparam logic [3:0] C_MRSN = 4'd7;
  localparam logic [3:0] C_MRSB = 4'd8;

  // Command cycles load N+1 so the command itself is the first count.
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] W_INIT = CNT_W'(INIT_WAIT);
  localparam logic [CNT_W-1:0] W_XSR  = CNT_W'(TXSR);
  localparam logic [CNT_W-1:0] W_RP1  = CNT_W'(TRP + 1);
  localparam logic [CNT_W-1:0] W_RFC1 = CNT_W'(TRFC + 1);
  localparam logic [CNT_W-1:0] W_MRD1 = CNT_W'(TMRD + 1);
  localparam logic [CNT_W-1:0] W_RCD1 = CNT_W'(TRCD + 1);
  localparam logic [CNT_W-1:0] W_CL1  = CNT_W'(CAS_LAT + 1);
  localparam logic [CNT_W-1:0] W_RP   = CNT_W'(TRP);
  localparam logic [CNT_W-1:0] W_WRRP = CNT_W'(TWR + TRP);
  localparam logic [CNT_W-1:0] W_BL   = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {
    ST_READY, ST_WAIT, ST_BEAT, ST_SREF
  } state_t;

  typedef enum logic [3:0] {
    G_NONE, G_INITW, G_PRE, G_REF1,
    G_REF2, G_MRS_HOME, G_RESTORE, G_DONE,
    G_SREF, G_XSR, G_MRS_NEED, G_ACT,
    G_RW, G_BEATS, G_POST
  } step_t;

  state_t           state;
  step_t            ret;
  step_t            go;
  logic [CNT_W-1:0] cnt;
  logic             op_init;
  logic             op_rd;
  logic             op_brst;
  logic             op_mode;
  logic             need;

  assign need = bus.opcode[2] & bus.opcode[0];

  // Pick the step to launch at this edge, or none.
  always_comb begin
    go = G_NONE;
    unique case (state)
      ST_READY: begin
        if (bus.start) begin
          if (bus.opcode == 3'd1)
            go = G_INITW;
          else if (bus.init_done) begin
            if (bus.opcode == 3'd2)
              go = G_PRE;
            else if (bus.opcode == 3'd3)
              go = G_REF1;
            else if (bus.opcode[2])
              go = (need != bus.mode_cur)
                 ? G_MRS_NEED : G_ACT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == ONE) begin
          if (ret == G_RESTORE)
            go = (bus.mode_cur != op_mode)
               ? G_MRS_HOME : G_DONE;
          else
            go = ret;
        end
      end
      ST_BEAT: begin
        if (cnt == ONE)
          go = G_POST;
      end
      ST_SREF: begin
        if (bus.start && bus.opcode == 3'd0)
          go = G_XSR;
      end
      default: go = G_NONE;
    endcase
  end

  // Sequencer state and registered command outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_READY;
      ret           <= G_NONE;
      cnt           <= '0;
      op_init       <= 1'b0;
      op_rd         <= 1'b0;
      op_brst       <= 1'b0;
      op_mode       <= 1'b0;
      bus.command   <= C_NOP;
      bus.chip      <= 1'b0;
      bus.idle      <= 1'b1;
      bus.done      <= 1'b0;
      bus.init_done <= 1'b0;
      bus.mode_cur  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == ST_READY && go != G_NONE) begin
        op_init <= (bus.opcode == 3'd1);
        op_rd   <= ~bus.opcode[1];
        op_brst <= need;
        op_mode <= bus.mode;
      end
      unique case (go)
        G_INITW: begin
          state       <= ST_WAIT;
          cnt         <= W_INIT;
          ret         <= G_PRE;
          bus.command <= C_NOP;
          bus.idle    <= 1'b0;
        end
        G_PRE: begin
          state       <= ST_WAIT;
          cnt         <= W_RP1;
          ret         <= (state == ST_READY)
                       ? G_SREF : G_REF1;
          bus.command <= C_PRE;
          bus.idle    <= 1'b0;
        end
        G_REF1: begin
          state       <= ST_WAIT;
          cnt         <= W_RFC1;
          ret         <= (state == ST_READY)
                       ? G_DONE : G_REF2;
          bus.command <= C_AREF;
          bus.idle    <= 1'b0;
        end
        G_REF2: begin
          state       <= ST_WAIT;
          cnt         <= W_RFC1;
          ret         <= G_MRS_HOME;
          bus.command <= C_AREF;
        end
        G_MRS_HOME: begin
          state        <= ST_WAIT;
          cnt          <= W_MRD1;
          ret          <= G_DONE;
          bus.command  <= op_mode ? C_MRSB : C_MRSN;
          bus.mode_cur <= op_mode;
        end
        G_DONE: begin
          state       <= ST_READY;
          bus.command <= C_NOP;
          bus.chip    <= 1'b0;
          bus.idle    <= 1'b1;
          bus.done    <= 1'b1;
          if (op_init)
            bus.init_done <= 1'b1;
        end
        G_SREF: begin
          state       <= ST_SREF;
          bus.command <= C_SREF;
          bus.idle    <= 1'b1;
          bus.done    <= 1'b1;
        end
        G_XSR: begin
          state       <= ST_WAIT;
          cnt         <= W_XSR;
          ret         <= G_DONE;
          bus.command <= C_NOP;
          bus.idle    <= 1'b0;
        end
        G_MRS_NEED: begin
          state        <= ST_WAIT;
          cnt          <= W_MRD1;
          ret          <= G_ACT;
          bus.command  <= need ? C_MRSB : C_MRSN;
          bus.mode_cur <= need;
          bus.idle     <= 1'b0;
        end
        G_ACT: begin
          state       <= ST_WAIT;
          cnt         <= W_RCD1;
          ret         <= G_RW;
          bus.command <= C_ACT;
          bus.idle    <= 1'b0;
        end
        G_RW: begin
          if (op_rd) begin
            state       <= ST_WAIT;
            cnt         <= W_CL1;
            ret         <= G_BEATS;
            bus.command <= C_RDA;
          end else begin
            state       <= ST_BEAT;
            cnt         <= op_brst ? W_BL : ONE;
            bus.command <= C_WRA;
            bus.chip    <= 1'b1;
          end
        end
        G_BEATS: begin
          state       <= ST_BEAT;
          cnt         <= op_brst ? W_BL : ONE;
          bus.command <= C_NOP;
          bus.chip    <= 1'b1;
        end
        G_POST: begin
          state       <= ST_WAIT;
          cnt         <= op_rd ? W_RP : W_WRRP;
          ret         <= G_RESTORE;
          bus.command <= C_NOP;
          bus.chip    <= 1'b0;
        end
        default: begin
          if (state == ST_WAIT || state == ST_BEAT) begin
            cnt         <= cnt - ONE;
            bus.command <= C_NOP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cmd_seq_param.sv
// Randomized bench for sdram_cmd_seq_param.
// A per-op expected command stream is built from the timing rules.
module tb_sdram_cmd_seq_param;

  localparam int BL  = 4;
  localparam int CL  = 2;
  localparam int RCD = 2;
  localparam int RP  = 2;
  localparam int RFC = 9;
  localparam int MRD = 2;
  localparam int WR  = 2;
  localparam int XSR = 10;
  localparam int IW  = 14285;

  typedef struct packed {
    logic [3:0] cmd;
    logic       chip;
    logic       idle;
    logic       done;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_cmd_seq_param_if bus();

  sdram_cmd_seq_param #(
    .BURST_LEN(BL), .CAS_LAT(CL), .TRCD(RCD),
    .TRP(RP), .TRFC(RFC), .TMRD(MRD), .TWR(WR),
    .TXSR(XSR), .INIT_WAIT(IW), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    m_init;
  bit    m_mc;
  bit    m_sref;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               tag, got, want);
    end
  endtask

  function automatic logic [6:0] obs();
    return {bus.command, bus.chip, bus.idle, bus.done};
  endfunction

  function automatic void put(input int c, input bit ch,
                              input bit id, input bit dn);
    beat_t b;
    b.cmd  = 4'(c);
    b.chip = ch;
    b.idle = id;
    b.done = dn;
    exp_q.push_back(b);
  endfunction

  function automatic void nops(input int n);
    for (int i = 0; i < n; i++) put(0, 0, 0, 0);
  endfunction

  function automatic beat_t rest();
    beat_t b;
    b.cmd  = m_sref ? 4'd6 : 4'd0;
    b.chip = 1'b0;
    b.idle = 1'b1;
    b.done = 1'b0;
    return b;
  endfunction

  function automatic bit accepts(input int op);
    if (m_sref) return op == 0;
    if (!m_init) return op == 1;
    return op != 0;
  endfunction

  function automatic int mrs(input bit b);
    return b ? 8 : 7;
  endfunction

  function automatic void build(input int op, input bit m);
    bit need;
    bit rd;
    int l;
    exp_q.delete();
    case (op)
      1: begin
        nops(IW);
        put(4, 0, 0, 0); nops(RP);
        put(5, 0, 0, 0); nops(RFC);
        put(5, 0, 0, 0); nops(RFC);
        put(mrs(m), 0, 0, 0); nops(MRD);
        m_mc = m;
        put(0, 0, 1, 1);
        m_init = 1;
      end
      2: begin
        put(4, 0, 0, 0); nops(RP);
        put(6, 0, 1, 1);
        m_sref = 1;
      end
      0: begin
        nops(XSR);
        put(0, 0, 1, 1);
        m_sref = 0;
      end
      3: begin
        put(5, 0, 0, 0); nops(RFC);
        put(0, 0, 1, 1);
      end
      default: begin
        need = (op == 5 || op == 7);
        rd   = (op < 6);
        l    = need ? BL : 1;
        if (need != m_mc) begin
          put(mrs(need), 0, 0, 0); nops(MRD);
          m_mc = need;
        end
        put(1, 0, 0, 0); nops(RCD);
        if (rd) begin
          put(2, 0, 0, 0); nops(CL);
          for (int i = 0; i < l; i++) put(0, 1, 0, 0);
          nops(RP);
        end else begin
          put(3, 1, 0, 0);
          for (int i = 1; i < l; i++) put(0, 1, 0, 0);
          nops(WR + RP);
        end
        if (m_mc != m) begin
          put(mrs(m), 0, 0, 0); nops(MRD);
          m_mc = m;
        end
        put(0, 0, 1, 1);
      end
    endcase
    exp_q.push_back(rest());
  endfunction

  task automatic resync();
    int n = 0;
    bus.start = 1'b0;
    while (!bus.idle && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check("resync_timeout", 0, 1);
  endtask

  task automatic run_op(input int op, input bit m);
    bit acc;
    int e0;
    bit bad = 0;
    acc = accepts(op);
    @(negedge clk);
    bus.opcode = 3'(op);
    bus.mode   = m;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (acc) build(op, m);
    else begin
      exp_q.delete();
      repeat (3) exp_q.push_back(rest());
    end
    foreach (exp_q[i]) begin
      e0 = errors;
      check($sformatf("op%0d_c%0d", op, i + 1),
            obs(), exp_q[i]);
      if (errors != e0) begin
        bad = 1;
        break;
      end
      if (!exp_q[i].idle && $urandom_range(0, 3) == 0) begin
        bus.opcode = 3'($urandom_range(0, 7));
        bus.start  = 1'b1;
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    if (bad) resync();
    check($sformatf("op%0d_init_done", op),
          bus.init_done, m_init);
    check($sformatf("op%0d_mode_cur", op),
          bus.mode_cur, m_mc);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("hold_c%0d", i), obs(), rest());
      @(negedge clk);
    end
  endtask

  task automatic rand_ops(input int n);
    int op;
    bit m;
    for (int i = 0; i < n; i++) begin
      if (m_sref && $urandom_range(0, 1) == 1) op = 0;
      else op = $urandom_range(0, 7);
      if (op == 1) op = 3;
      m = 1'($urandom_range(0, 1));
      run_op(op, m);
    end
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.opcode = 3'd0;
    bus.mode   = 1'b0;
    m_init = 0;
    m_mc   = 0;
    m_sref = 0;
    repeat (2) @(negedge clk);
    check("rst_command", bus.command, 0);
    check("rst_chip", bus.chip, 0);
    check("rst_idle", bus.idle, 1);
    check("rst_done", bus.done, 0);
    check("rst_init_done", bus.init_done, 0);
    check("rst_mode_cur", bus.mode_cur, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(4, 0);
    run_op(1, 0);
    run_op(6, 0);
    run_op(1, 1);
    run_op(5, 1);
    run_op(4, 1);
    run_op(2, 1);
    hold(20);
    run_op(3, 1);
    run_op(0, 1);
    rand_ops(40);
    if (m_sref) run_op(0, 1);

    @(negedge clk);
    bus.opcode = 3'd5;
    bus.mode   = 1'b1;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.chip && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("burst_chip_seen", bus.chip, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_command", bus.command, 0);
    check("mid_rst_chip", bus.chip, 0);
    check("mid_rst_idle", bus.idle, 1);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_init_done", bus.init_done, 0);
    check("mid_rst_mode_cur", bus.mode_cur, 0);
    rst = 1'b0;
    m_init = 0;
    m_mc   = 0;
    m_sref = 0;
    run_op(4, 1);
    run_op(1, 1);
    rand_ops(12);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_seq_param.md
Name: sdram_cmd_seq_param

Overview:
Parametrised SDRAM command sequencer, the successor to the fixed-timing subroutine command generator. Accepts an opcode from the controller FSM and emits a cycle-accurate SDRAM command stream: init, self-refresh, auto-refresh, and single or burst read/write with auto-precharge. All timing and burst length come from parameters. Tracks the programmed mode register and inserts MRS reprogram/restore commands automatically. Sits between the controller FSM and the SDRAM pin driver.

Parameters:
BURST_LEN, 4, beats per burst access (≥2)
CAS_LAT, 2, NOP cycles between READ_AP and first read beat
TRCD, 2, NOP cycles after ACTIVE
TRP, 2, NOP cycles after PRE_ALL and after auto-precharge
TRFC, 9, NOP cycles after AUTO_REF
TMRD, 2, NOP cycles after MRS
TWR, 2, write-recovery NOP cycles before TRP
TXSR, 10, NOP cycles after self-refresh exit
INIT_WAIT, 14285, NOP cycles after init start before PRE_ALL
CNT_W, 16, wait-counter width; must hold the largest timing parameter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  request strobe; opcode is sampled when start=1 and idle=1
opcode  in  3  0 SREF_EXIT, 1 INIT, 2 SREF_ENTER, 3 AUTO_REF, 4 READ_NB, 5 READ_BRST, 6 WRITE_NB, 7 WRITE_BRST
mode  in  1  home mode: 0 non-burst, 1 burst
command  out  4  0 NOP, 1 ACTIVE, 2 READ_AP, 3 WRITE_AP, 4 PRE_ALL, 5 AUTO_REF, 6 SELF_REF, 7 MRS_NB, 8 MRS_BRST
chip  out  1  data-bus valid window (read beat / write beat)
idle  out  1  ready to accept start
done  out  1  one-cycle completion pulse
init_done  out  1  init sequence has completed since reset
mode_cur  out  1  mode currently programmed in the SDRAM

Behaviour:
- Reset values: command=0, chip=0, idle=1, done=0, init_done=0, mode_cur=0. State is READY; all counters are 0. Reset mid-sequence aborts immediately; no completion or restore commands are issued.
- All outputs are registered. Acceptance edge = C0. The first command appears in cycle C1. idle=0 from C1 until the cycle done=1.
- Each command lasts exactly one cycle. Every other cycle outputs NOP unless in the SREF state.
- done and idle=1 assert together in the cycle after the final wait cycle.
- When init_done=0, only opcode 1 is accepted; other opcodes are ignored and idle stays 1.
- INIT: INIT_WAIT NOPs → PRE_ALL+TRP → AUTO_REF+TRFC → AUTO_REF+TRFC → MRS(mode)+TMRD → done. On the MRS, mode_cur←mode; init_done←1 at done. A re-INIT is legal at any time from READY.
- SREF_ENTER: PRE_ALL+TRP, then enter SREF. In SREF, command=6 every cycle, idle=1, and done pulses on entry. In SREF only opcode 0 is accepted; others are ignored. Opcode 0 in READY is a no-op with no done.
- SREF_EXIT (from SREF): TXSR NOPs → done.
- AUTO_REF: AUTO_REF+TRFC → done.
- Access mode: need = 1 for opcodes 5 and 7, else 0.
  - If need≠mode_cur, issue MRS(need)+TMRD first and set mode_cur.
  - After the access, if mode_cur≠mode, issue MRS(mode)+TMRD to restore.
- Beat count: L = BURST_LEN for bursts, 1 for single accesses.
- READ: ACTIVE+TRCD → READ_AP → CAS_LAT NOPs (chip=0) → L cycles with chip=1 → TRP NOPs → [restore] → done.
- WRITE: ACTIVE+TRCD → WRITE_AP with chip=1 in that cycle and the next L-1 cycles → TWR+TRP NOPs → [restore] → done.
- chip=0 in all other cycles.
- start while idle=0 is ignored and not queued.
- Waits are counted with one down-counter loaded with the parameter value. A parameter value of 0 is illegal; behaviour for it is undefined.

Test Plan:
- Defaults; rst pulse; opcode 1, mode=0 → INIT_WAIT NOPs, 4, NOP×2, 5, NOP×9, 5, NOP×9, 7, NOP×2, done; init_done=1, mode_cur=0.
- After init with mode=0; opcode 6 → C1 ACTIVE, C2–3 NOP, C4 WRITE_AP with chip=1, C5–8 NOP, C9 done.
- After init with mode=1; opcode 5 → C1 ACTIVE, C4 READ_AP, C5–6 NOP, C7–10 chip=1, C11–12 NOP, C13 done; no MRS issued.
- mode=1, mode_cur=1; opcode 4 → MRS_NB(7)+2 NOP, ACTIVE, READ_AP, single chip beat, TRP NOPs, then MRS_BRST(8)+2 NOP, done; mode_cur ends at 1.
- opcode 2 → 4, NOP×2, then 6 held for 20 cycles with idle=1. Send opcode 3 → ignored. Send opcode 0 → NOP×10, then done.
- Assert rst during the chip window of a burst read → next cycle command=0, chip=0, idle=1, init_done=0. A subsequent opcode 4 is ignored until INIT completes.
